// File: rtl/lcd_src_arbiter.sv
// Frame-synchronous arbiter choosing which of two pixel generators feeds the
// RGB LCD timing driver. Ownership only changes at the end of a visible frame,
// so a switch never tears a frame. The pixel mux is combinational from a
// registered grant, keeping the driver's one-cycle request-to-data budget.
module lcd_src_arbiter #(
    parameter int unsigned  MIN_FRAMES = 4,
    parameter logic [23:0]  BG_COLOR   = 24'h000000
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic [10:0] v_disp,
    input  logic        lcd_de,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] src0_data,
    input  logic [23:0] src1_data,
    output logic [23:0] pixel_data,
    output logic [1:0]  grant,
    output logic        frame_end,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [8:0] MIN_F = 9'(MIN_FRAMES);

    state_t      state_reg, state_next;
    logic        de_d_reg;
    logic [10:0] line_cnt_reg;
    logic        frame_end_reg;
    logic [15:0] frame_cnt_reg;
    logic [7:0]  dwell_reg, dwell_next;
    logic        last_reg, last_next;
    logic [1:0]  grant_reg, grant_next;

    logic        de_rise;
    logic        de_fall;
    logic        boundary;
    logic [8:0]  dwell_inc;

    assign de_rise   = lcd_de & ~de_d_reg;
    assign de_fall   = ~lcd_de & de_d_reg;
    // '>=' lets a mid-frame shrink of v_disp still close the frame at the next line end
    assign boundary  = de_fall && (line_cnt_reg >= v_disp);
    assign dwell_inc = {1'b0, dwell_reg} + 9'd1;

    // DE edge history, active-line counter and frame boundary bookkeeping
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            de_d_reg      <= 1'b0;
            line_cnt_reg  <= 11'd0;
            frame_end_reg <= 1'b0;
            frame_cnt_reg <= 16'd0;
        end else begin
            de_d_reg      <= lcd_de;
            frame_end_reg <= 1'b0;
            if (de_rise) begin
                if (line_cnt_reg != 11'h7FF)
                    line_cnt_reg <= line_cnt_reg + 11'd1;
            end else if (boundary) begin
                line_cnt_reg  <= 11'd0;
                frame_end_reg <= 1'b1;
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    // Arbitration state, dwell, round-robin pointer and registered grant
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            dwell_reg <= 8'd0;
            last_reg  <= 1'b1;
            grant_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            dwell_reg <= dwell_next;
            last_reg  <= last_next;
            grant_reg <= grant_next;
        end
    end

    // Next owner decided only at a frame boundary; requests elsewhere are ignored
    always_comb begin
        state_next = state_reg;
        dwell_next = dwell_reg;
        last_next  = last_reg;
        grant_next = 2'b00;
        if (boundary) begin
            case (state_reg)
                IDLE: begin
                    if (req0 && req1)
                        state_next = last_reg ? OWN0 : OWN1;
                    else if (req0)
                        state_next = OWN0;
                    else if (req1)
                        state_next = OWN1;
                end
                OWN0: begin
                    if (!req0)
                        state_next = req1 ? OWN1 : IDLE;
                    else if (req1 && (dwell_inc >= MIN_F))
                        state_next = OWN1;
                end
                OWN1: begin
                    if (!req1)
                        state_next = req0 ? OWN0 : IDLE;
                    else if (req0 && (dwell_inc >= MIN_F))
                        state_next = OWN0;
                end
                default: state_next = IDLE;
            endcase
            if (state_next != state_reg) begin
                dwell_next = 8'd0;
                if (state_next == OWN0)
                    last_next = 1'b0;
                else if (state_next == OWN1)
                    last_next = 1'b1;
            end else if (state_reg != IDLE) begin
                // owner kept its request: count the frame, saturating at the minimum dwell
                dwell_next = (dwell_inc >= MIN_F) ? MIN_F[7:0] : dwell_inc[7:0];
            end
        end
        case (state_next)
            OWN0:    grant_next = 2'b01;
            OWN1:    grant_next = 2'b10;
            default: grant_next = 2'b00;
        endcase
    end

    // Zero-latency pixel mux steered by the registered grant
    always_comb begin
        case (grant_reg)
            2'b01:   pixel_data = src0_data;
            2'b10:   pixel_data = src1_data;
            default: pixel_data = BG_COLOR;
        endcase
    end

    assign grant     = grant_reg;
    assign frame_end = frame_end_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_lcd_src_arbiter.sv
// Testbench for lcd_src_arbiter: directed frame table, hand-written corner
// sequences and randomized DE/request traffic against a behavioural model.
module tb_lcd_src_arbiter;

    localparam int          MINF = 2;
    localparam logic [23:0] BG   = 24'h5AA53C;

    logic        lcd_pclk = 1'b0;
    logic        rst_n;
    logic [10:0] v_disp;
    logic        lcd_de;
    logic        req0, req1;
    logic [23:0] src0_data, src1_data;
    logic [23:0] pixel_data;
    logic [1:0]  grant;
    logic        frame_end;
    logic [15:0] frame_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int fe_seen = 0;
    bit model_on = 1'b0;

    lcd_src_arbiter #(.MIN_FRAMES(MINF), .BG_COLOR(BG)) dut (
        .lcd_pclk   (lcd_pclk),
        .rst_n      (rst_n),
        .v_disp     (v_disp),
        .lcd_de     (lcd_de),
        .req0       (req0),
        .req1       (req1),
        .src0_data  (src0_data),
        .src1_data  (src1_data),
        .pixel_data (pixel_data),
        .grant      (grant),
        .frame_end  (frame_end),
        .frame_cnt  (frame_cnt)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // owner: -1 none, 0 or 1 for a source
    typedef struct {
        int owner;
        int last;
        int dwell;
    } arb_t;

    function automatic arb_t arb_step(input arb_t s, input bit r0, input bit r1);
        arb_t n;
        bit   r [2];
        int   want, me, other;
        n = s;
        r[0] = r0;
        r[1] = r1;
        want = -1;
        if (s.owner < 0) begin
            if (r0 && r1)  want = 1 - s.last;
            else if (r0)   want = 0;
            else if (r1)   want = 1;
        end else begin
            me    = s.owner;
            other = 1 - s.owner;
            if (!r[me])                               want = r[other] ? other : -1;
            else if (r[other] && s.dwell + 1 >= MINF) want = other;
            else                                      want = me;
        end
        if (want != s.owner) begin
            n.owner = want;
            n.dwell = 0;
            if (want >= 0) n.last = want;
        end else if (want >= 0) begin
            n.dwell = (s.dwell + 1 < MINF) ? s.dwell + 1 : MINF;
        end
        return n;
    endfunction

    function automatic int owner_grant(input int owner);
        return (owner == 0) ? 1 : (owner == 1) ? 2 : 0;
    endfunction

    arb_t m_arb;
    int   m_lines;
    bit   m_prev_de;
    bit   m_fe;
    int   m_fcnt;

    always @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            m_arb     <= '{owner: -1, last: 1, dwell: 0};
            m_lines   <= 0;
            m_prev_de <= 1'b0;
            m_fe      <= 1'b0;
            m_fcnt    <= 0;
        end else begin
            m_prev_de <= lcd_de;
            m_fe      <= 1'b0;
            if (lcd_de && !m_prev_de) begin
                m_lines <= (m_lines >= 2047) ? 2047 : m_lines + 1;
            end else if (!lcd_de && m_prev_de && m_lines >= int'(v_disp)) begin
                m_lines <= 0;
                m_fe    <= 1'b1;
                m_fcnt  <= (m_fcnt + 1) % 65536;
                m_arb   <= arb_step(m_arb, req0, req1);
            end
        end
    end

    // every cycle, shortly after the edge, compare DUT against the model
    always begin
        @(posedge lcd_pclk);
        #1;
        if (model_on && rst_n) begin
            chk("m_grant", 32'(grant), 32'(owner_grant(m_arb.owner)));
            chk("m_frame_end", 32'(frame_end), 32'(m_fe));
            chk("m_frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
            chk("m_pixel", 32'(pixel_data),
                32'((m_arb.owner == 0) ? src0_data : (m_arb.owner == 1) ? src1_data : BG));
        end
    end

    // frame_end pulse counter
    always @(posedge lcd_pclk) begin
        if (frame_end === 1'b1) fe_seen <= fe_seen + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge lcd_pclk);
    endtask

    task automatic line(input int act, input int blank);
        for (int p = 0; p < act; p++) begin
            lcd_de = 1'b1;
            src0_data = 24'($urandom);
            src1_data = 24'($urandom);
            tick();
        end
        for (int p = 0; p < blank; p++) begin
            lcd_de = 1'b0;
            tick();
        end
    endtask

    function automatic logic [23:0] exp_pix(input logic [1:0] g);
        return (g == 2'b01) ? src0_data : (g == 2'b10) ? src1_data : BG;
    endfunction

    typedef struct {
        bit         r0;
        bit         r1;
        logic [1:0] g;
    } vec_t;

    vec_t       tbl [12];
    logic [1:0] prev_g;
    int         fe0;
    bit         got;

    initial begin
        // frame table: requests change mid-frame (after line 2); grant after the boundary
        tbl[0]  = '{1'b1, 1'b0, 2'b01};
        tbl[1]  = '{1'b1, 1'b0, 2'b01};
        tbl[2]  = '{1'b1, 1'b1, 2'b10};
        tbl[3]  = '{1'b1, 1'b1, 2'b10};
        tbl[4]  = '{1'b1, 1'b1, 2'b01};
        tbl[5]  = '{1'b0, 1'b1, 2'b10};
        tbl[6]  = '{1'b0, 1'b0, 2'b00};
        tbl[7]  = '{1'b1, 1'b1, 2'b01};
        tbl[8]  = '{1'b0, 1'b0, 2'b00};
        tbl[9]  = '{1'b0, 1'b1, 2'b10};
        tbl[10] = '{1'b1, 1'b1, 2'b10};
        tbl[11] = '{1'b1, 1'b0, 2'b01};

        rst_n = 1'b0;
        v_disp = 11'd4;
        lcd_de = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        src0_data = 24'h111111;
        src1_data = 24'h222222;
        repeat (3) tick();

        // reset state
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_frame_end", 32'(frame_end), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_pixel", 32'(pixel_data), 32'(BG));
        rst_n = 1'b1;
        model_on = 1'b1;
        tick();

        // directed frame table
        prev_g = 2'b00;
        for (int i = 0; i < 12; i++) begin
            fe0 = fe_seen;
            line(3, 2);
            line(3, 2);
            chk("tbl_hold", 32'(grant), 32'(prev_g));
            req0 = tbl[i].r0;
            req1 = tbl[i].r1;
            line(3, 2);
            line(3, 2);
            chk("tbl_grant", 32'(grant), 32'(tbl[i].g));
            chk("tbl_frame_cnt", 32'(frame_cnt), 32'(i + 1));
            chk("tbl_fe_pulses", 32'(fe_seen - fe0), 32'd1);
            chk("tbl_pixel", 32'(pixel_data), 32'(exp_pix(tbl[i].g)));
            prev_g = tbl[i].g;
        end

        // no tearing: req1 pulses only between boundaries while source 0 owns
        req0 = 1'b1;
        req1 = 1'b0;
        for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 3; p++) begin
                lcd_de = 1'b1;
                req1 = (l == 1);
                src0_data = 24'($urandom);
                src1_data = 24'($urandom);
                #1;
                chk("tear_pixel", 32'(pixel_data), 32'(src0_data));
                tick();
            end
            lcd_de = 1'b0;
            req1 = 1'b0;
            repeat (2) tick();
        end
        chk("tear_grant", 32'(grant), 32'd1);
        chk("tear_frame_cnt", 32'(frame_cnt), 32'd13);

        // resize: v_disp 8 -> 3 during line 5 ends the frame at that line
        v_disp = 11'd8;
        fe0 = fe_seen;
        repeat (4) line(3, 2);
        chk("resize_no_early", 32'(fe_seen - fe0), 32'd0);
        lcd_de = 1'b1;
        tick();
        v_disp = 11'd3;
        line(2, 3);
        chk("resize_fe_pulses", 32'(fe_seen - fe0), 32'd1);
        chk("resize_frame_cnt", 32'(frame_cnt), 32'd14);
        v_disp = 11'd4;

        // reset mid-frame while source 1 owns
        req0 = 1'b0;
        req1 = 1'b1;
        repeat (4) line(3, 2);
        chk("prerst_grant", 32'(grant), 32'd2);
        line(3, 2);
        lcd_de = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_pixel", 32'(pixel_data), 32'(BG));
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        line(2, 2);
        chk("postrst_grant", 32'(grant), 32'd0);
        fe0 = fe_seen;
        got = 1'b0;
        for (int l = 0; l < 20 && !got; l++) begin
            line(3, 2);
            if (fe_seen != fe0) got = 1'b1;
        end
        chk("postrst_boundary_seen", 32'(got), 32'd1);
        chk("postrst_grant_after", 32'(grant), 32'd2);

        // randomized traffic, checked every cycle by the model
        for (int l = 0; l < 300; l++) begin
            if ($urandom_range(0, 9) == 0) v_disp = 11'($urandom_range(1, 5));
            if ($urandom_range(0, 2) == 0) req0 = ~req0;
            if ($urandom_range(0, 2) == 0) req1 = ~req1;
            for (int p = 0; p < int'($urandom_range(1, 4)); p++) begin
                lcd_de = 1'b1;
                src0_data = 24'($urandom);
                src1_data = 24'($urandom);
                if ($urandom_range(0, 7) == 0) req1 = ~req1;
                tick();
            end
            for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
                lcd_de = 1'b0;
                src0_data = 24'($urandom);
                src1_data = 24'($urandom);
                tick();
            end
            if (l == 150) begin
                #2 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end

        model_on = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_src_arbiter.md
# lcd_src_arbiter

Frame-synchronous pixel-source arbiter between two pixel generators (e.g. pattern/overlay engines) and the RGB LCD timing driver. It counts active lines from the driver's data-enable, detects the end of each visible frame, and changes source ownership only at that boundary, so a switch never tears a frame. The pixel mux is combinational from a registered grant, which preserves the driver's one-cycle pixel-request-to-data budget.

## Interface
Parameters:
- `MIN_FRAMES`, default 4: minimum frames an owner keeps the grant while the other source is requesting (range 1..255).
- `BG_COLOR`, default 24'h000000: RGB888 value driven when no source owns the display.

Ports:
- `lcd_pclk`, in, 1: pixel clock, the single clock domain.
- `rst_n`, in, 1: asynchronous reset, active-low.
- `v_disp`, in, 11: active lines per frame, taken from the timing driver.
- `lcd_de`, in, 1: data enable from the timing driver.
- `req0`, in, 1: source 0 requests the display (level).
- `req1`, in, 1: source 1 requests the display (level).
- `src0_data`, in, 24: source 0 RGB888 pixel.
- `src1_data`, in, 24: source 1 RGB888 pixel.
- `pixel_data`, out, 24: pixel to the timing driver.
- `grant`, out, 2: one-hot owner; 2'b00 means none.
- `frame_end`, out, 1: one-cycle pulse at each detected frame boundary.
- `frame_cnt`, out, 16: count of frame_end pulses, wraps.

## Operation
- Edge detection:
  - `de_d` is `lcd_de` registered.
  - A rise is `lcd_de & ~de_d`.
  - A fall is `~lcd_de & de_d`.
- Line counter `line_cnt` (11 bits):
  - On each rise it increments, saturating at 2047.
  - On a fall with `line_cnt >= v_disp` it clears to 0. This is the frame boundary.
- Frame boundary effects:
  - `frame_end` is registered high for exactly one cycle.
  - `frame_cnt` increments, wrapping from 65535 to 0.
  - Arbitration is evaluated. `grant` never changes at any other time.
- Using `>=` rather than `==` means a `v_disp` decrease mid-frame still ends the frame at the next line end.
- A mid-frame reset release gives a short first frame or a late first boundary. This is accepted.
- FSM states are IDLE, OWN0 and OWN1. Reset enters IDLE.
- Round-robin pointer `last` is 1 after reset, so source 0 wins the first tie.
- Dwell counter `dwell` (8 bits) clears on every grant change.
- At a frame boundary:
  - IDLE:
    - Both requesting: go to OWN(1-last).
    - Only one requesting: go to that source's state.
    - Neither requesting: stay in IDLE.
  - OWNx with `reqx` low:
    - If the other source is requesting, go to OWN(other).
    - Otherwise go to IDLE.
  - OWNx with `reqx` high:
    - If the other source is requesting and `dwell+1 >= MIN_FRAMES`, go to OWN(other).
    - Otherwise stay in OWNx, with `dwell <= min(dwell+1, MIN_FRAMES)`.
  - On every entry to OWNx, set `last <= x`.
- Requests are sampled only at the boundary cycle. Pulses between boundaries are ignored.
- Pixel mux (combinational):
  - `grant==01`: `src0_data`.
  - `grant==10`: `src1_data`.
  - Otherwise: `BG_COLOR`.
- `grant` is decoded from the FSM state and is registered.

## Timing
- Reset values:
  - `grant`=00, `frame_end`=0, `frame_cnt`=0.
  - `pixel_data`=`BG_COLOR`.
  - `line_cnt`=0, `de_d`=0, `dwell`=0, `last`=1.
- Boundary timing:
  - Edge E is the first clock edge that samples `lcd_de`=0 after the last active pixel of line `v_disp`.
  - At E, `grant`, `frame_end`, `frame_cnt` and the FSM update together.
  - The new `pixel_data` source is visible in the cycle after E, inside vertical blanking.
- `pixel_data` has zero-cycle latency from `srcN_data` and no added pipeline stage.
- A rise and a fall cannot occur in the same cycle, so no simultaneous-event conflict exists on `line_cnt`.
- Asynchronous reset mid-frame returns all state to reset values immediately. The display shows `BG_COLOR` until the first boundary that sees a request.

## Test plan
- **Single requester from reset.** Setup: `v_disp`=4, 3 frames of 4 DE lines, `req0`=1 throughout. Required: `grant` 00→01 at the first boundary; `frame_end` pulses 3 times; `frame_cnt`=3.
- **Contention with dwell.** Setup: `MIN_FRAMES`=2, `req0` and `req1` both high from reset. Required: `grant` reaches 01 at boundary 1 and switches to 10 at boundary 3 (after 2 owned frames).
- **Release mid-frame.** Setup: owner 0; drop `req0` mid-frame with `req1`=0. Required: `grant` holds 01 until the boundary, then 00; `pixel_data`=`BG_COLOR` afterwards.
- **No tearing.** Setup: pulse `req1` high only between boundaries while `req0`=1. Required: `grant` stays 01; `pixel_data` equals `src0_data` on every DE cycle.
- **Resize mid-frame.** Setup: `v_disp` 8→3 after line 5 of a frame. Required: boundary at the end of line 5 (`line_cnt` 5>=3); `frame_end` pulses once.
- **Reset mid-frame.** Setup: assert `rst_n`=0 while `grant`=10. Required: `grant`=00 and `pixel_data`=`BG_COLOR` asynchronously; after release, a grant appears only at a later boundary.
